seq_divider: RTL and testbench

- Iterative multi-cycle divider; the inverse operation of the team's combinational multiplier.
- Takes a double-width dividend (product-sized, 2*DATA_WIDTH) and a DATA_WIDTH divisor.
- Returns a double-width quotient and a DATA_WIDTH remainder.
- Uses a restoring shift-subtract datapath with valid/ready handshakes on input and output; sits on arithmetic datapaths that must undo or normalise multiplier products.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 157 +++++++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and data bundle for seq_divider.
// master: the side issuing operations and consuming results.
// slave:  the divider itself.
interface seq_divider_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*DATA_WIDTH-1:0]   dividend;
    logic [DATA_WIDTH-1:0]     divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]     remainder;
    logic                      div_by_zero;
    logic                      overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2*DATA_WIDTH dividend / DATA_WIDTH divisor,
// returning a 2*DATA_WIDTH quotient and a DATA_WIDTH remainder.
// Latency: out_valid rises 2*DATA_WIDTH+1 edges after the accept edge.
// Backpressure: results held in DONE until out_ready; no new accept until then.
// Ports: clk, rst (async, active-high), bus (seq_divider_if.slave).
module seq_divider #(
    parameter int DATA_WIDTH = 8,
    parameter bit SIGNED_DIV = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int                DW        = 2 * DATA_WIDTH;
    localparam int                CNT_W     = $clog2(DW);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DW - 1);
    localparam logic [DW-1:0]     MIN_DVD   = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in.
    logic [DW-1:0]           dvd_q;
    logic [DATA_WIDTH:0]     rem_q;
    logic [DATA_WIDTH-1:0]   dvs_q;
    logic [DATA_WIDTH-1:0]   dlo_q;
    logic                    qneg_q;
    logic                    rneg_q;
    logic                    dbz_cap_q;
    logic                    ovf_cap_q;

    logic                    out_valid_q;
    logic [DW-1:0]           quot_q;
    logic [DATA_WIDTH-1:0]   remo_q;
    logic                    dbz_q;
    logic                    ovf_q;

    // Operand conditioning at capture time.
    logic                    dvd_neg;
    logic                    dvs_neg;
    logic [DW-1:0]           dvd_mag_d;
    logic [DATA_WIDTH-1:0]   dvs_mag_d;
    logic                    dbz_d;
    logic                    ovf_d;

    always_comb begin
        dvd_neg   = SIGNED_DIV && bus.dividend[DW-1];
        dvs_neg   = SIGNED_DIV && bus.divisor[DATA_WIDTH-1];
        // |-2^(n-1)| wraps to 2^(n-1), which is correct read as unsigned.
        dvd_mag_d = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag_d = dvs_neg ? -bus.divisor  : bus.divisor;
        dbz_d     = (bus.divisor == '0);
        ovf_d     = SIGNED_DIV && (bus.dividend == MIN_DVD) && (bus.divisor == '1);
    end

    // One restoring step. The partial remainder is always < |divisor|, so its
    // low DATA_WIDTH bits plus the incoming dividend bit lose nothing.
    logic [DATA_WIDTH:0]     rem_shift;
    logic                    sub_ok;
    logic [DATA_WIDTH:0]     rem_d;
    logic [DW-1:0]           dvd_d;

    always_comb begin
        rem_shift = {rem_q[DATA_WIDTH-1:0], dvd_q[DW-1]};
        sub_ok    = (rem_shift >= {1'b0, dvs_q});
        rem_d     = sub_ok ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        dvd_d     = {dvd_q[DW-2:0], sub_ok};
    end

    // Sign fix-up and special cases, registered in FIX.
    logic [DW-1:0]           quot_d;
    logic [DATA_WIDTH-1:0]   remo_d;

    always_comb begin
        quot_d = qneg_q ? -dvd_q : dvd_q;
        remo_d = rneg_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
        if (dbz_cap_q) begin
            quot_d = '1;
            remo_d = dlo_q;
        end else if (ovf_cap_q) begin
            quot_d = MIN_DVD;
            remo_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            dlo_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dbz_cap_q   <= 1'b0;
            ovf_cap_q   <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            remo_q      <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvd_q     <= dvd_mag_d;
                        dvs_q     <= dvs_mag_d;
                        dlo_q     <= bus.dividend[DATA_WIDTH-1:0];
                        rem_q     <= '0;
                        qneg_q    <= dvd_neg ^ dvs_neg;
                        rneg_q    <= dvd_neg;
                        dbz_cap_q <= dbz_d;
                        ovf_cap_q <= ovf_d;
                        cnt_q     <= '0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q      <= quot_d;
                    remo_q      <= remo_d;
                    dbz_q       <= dbz_cap_q;
                    ovf_q       <= ovf_cap_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        quot_q      <= '0;
                        remo_q      <= '0;
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench: one unsigned and one signed divider fed identical operands,
// each checked against hand-computed results, latency and handshake timing.
module tb_seq_divider;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_divider_if #(.DATA_WIDTH(8)) ifu ();
    seq_divider_if #(.DATA_WIDTH(8)) ifs ();

    seq_divider #(.DATA_WIDTH(8), .SIGNED_DIV(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(ifu));
    seq_divider #(.DATA_WIDTH(8), .SIGNED_DIV(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] uq;
        logic [7:0]  ur;
        logic        udz;
        logic [15:0] sq;
        logic [7:0]  sr;
        logic        sdz;
        logic        sov;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_ops(input logic v, input logic [15:0] a, input logic [7:0] b);
        ifu.in_valid = v; ifu.dividend = a; ifu.divisor = b;
        ifs.in_valid = v; ifs.dividend = a; ifs.divisor = b;
    endtask

    task automatic set_out_ready(input logic r);
        ifu.out_ready = r;
        ifs.out_ready = r;
    endtask

    // Present operands for one edge, then scramble them to show they are not
    // re-sampled after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        chk("in_ready_u before accept", {31'b0, ifu.in_ready}, 32'd1);
        chk("in_ready_s before accept", {31'b0, ifs.in_ready}, 32'd1);
        drive_ops(1'b1, a, b);
        @(posedge clk);
        #1;
        drive_ops(1'b0, ~a, ~b);
    endtask

    // Counts edges from the accept edge until both out_valid are seen.
    // With junk=1, in_valid toggles with random operands while busy.
    task automatic wait_done(input logic junk, output int lu, output int ls);
        lu = 0;
        ls = 0;
        for (int k = 2; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ifu.out_valid && lu == 0) lu = k;
            if (ifs.out_valid && ls == 0) ls = k;
            if (lu != 0 && ls != 0) break;
            if (junk) drive_ops(k[0], 16'($urandom), 8'($urandom));
        end
        drive_ops(1'b0, 16'h0, 8'h0);
    endtask

    task automatic check_result(input vec_t v);
        chk("quot_u",   {16'b0, ifu.quotient},    {16'b0, v.uq});
        chk("rem_u",    {24'b0, ifu.remainder},   {24'b0, v.ur});
        chk("dbz_u",    {31'b0, ifu.div_by_zero}, {31'b0, v.udz});
        chk("ovf_u",    {31'b0, ifu.overflow},    32'd0);
        chk("quot_s",   {16'b0, ifs.quotient},    {16'b0, v.sq});
        chk("rem_s",    {24'b0, ifs.remainder},   {24'b0, v.sr});
        chk("dbz_s",    {31'b0, ifs.div_by_zero}, {31'b0, v.sdz});
        chk("ovf_s",    {31'b0, ifs.overflow},    {31'b0, v.sov});
    endtask

    // Accept edge counts as edge 1 in wait_done, so 17 edges later is 18.
    task automatic run_vec(input vec_t v);
        int lu, ls;
        set_out_ready(1'b1);
        start_op(v.a, v.b);
        wait_done(1'b0, lu, ls);
        chk("latency_u", 32'(lu - 1), 32'd17);
        chk("latency_s", 32'(ls - 1), 32'd17);
        check_result(v);
        @(posedge clk);
        #1;
        chk("out_valid_u drop", {31'b0, ifu.out_valid},   32'd0);
        chk("out_valid_s drop", {31'b0, ifs.out_valid},   32'd0);
        chk("in_ready_u back",  {31'b0, ifu.in_ready},    32'd1);
        chk("in_ready_s back",  {31'b0, ifs.in_ready},    32'd1);
        chk("dbz_s cleared",    {31'b0, ifs.div_by_zero}, 32'd0);
    endtask

    initial begin
        int  lu, ls;
        logic seen;
        //             a         b      uq        ur     udz   sq        sr     sdz   sov
        vt[0]  = '{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16'h008E, 8'h06, 1'b0, 1'b0};
        vt[1]  = '{16'hFC18, 8'h07, 16'h2403, 8'h03, 1'b0, 16'hFF72, 8'hFA, 1'b0, 1'b0};
        vt[2]  = '{16'h03E8, 8'hF9, 16'h0004, 8'h04, 1'b0, 16'hFF72, 8'h06, 1'b0, 1'b0};
        vt[3]  = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 16'hFFFF, 8'h34, 1'b1, 1'b0};
        vt[4]  = '{16'hFC18, 8'h00, 16'hFFFF, 8'h18, 1'b1, 16'hFFFF, 8'h18, 1'b1, 1'b0};
        vt[5]  = '{16'h8000, 8'hFF, 16'h0080, 8'h80, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1};
        vt[6]  = '{16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0, 16'h000F, 8'h0F, 1'b0, 1'b0};
        vt[7]  = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0};
        vt[8]  = '{16'h0005, 8'h0A, 16'h0000, 8'h05, 1'b0, 16'h0000, 8'h05, 1'b0, 1'b0};
        vt[9]  = '{16'hFFF9, 8'hFE, 16'h0101, 8'hFB, 1'b0, 16'h0003, 8'hFF, 1'b0, 1'b0};
        vt[10] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b0};
        vt[11] = '{16'h8000, 8'h01, 16'h8000, 8'h00, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b0};
        vt[12] = '{16'h7FFF, 8'h80, 16'h00FF, 8'h7F, 1'b0, 16'hFF01, 8'h7F, 1'b0, 1'b0};
        vt[13] = '{16'hFFFF, 8'hFE, 16'h0102, 8'h03, 1'b0, 16'h0000, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        drive_ops(1'b0, 16'h0, 8'h0);
        set_out_ready(1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in_ready_u",  {31'b0, ifu.in_ready},    32'd1);
        chk("reset out_valid_u", {31'b0, ifu.out_valid},   32'd0);
        chk("reset quot_u",      {16'b0, ifu.quotient},    32'd0);
        chk("reset rem_u",       {24'b0, ifu.remainder},   32'd0);
        chk("reset dbz_s",       {31'b0, ifs.div_by_zero}, 32'd0);
        chk("reset ovf_s",       {31'b0, ifs.overflow},    32'd0);

        for (int i = 0; i < 14; i++) run_vec(vt[i]);

        // Backpressure with junk traffic on the input side while busy.
        set_out_ready(1'b0);
        start_op(16'h03E8, 8'h07);
        wait_done(1'b1, lu, ls);
        chk("bp latency_u", 32'(lu - 1), 32'd17);
        chk("bp latency_s", 32'(ls - 1), 32'd17);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid_u", {31'b0, ifu.out_valid}, 32'd1);
            chk("bp in_ready_u",  {31'b0, ifu.in_ready},  32'd0);
            chk("bp in_ready_s",  {31'b0, ifs.in_ready},  32'd0);
            check_result(vt[0]);
        end
        @(negedge clk);
        set_out_ready(1'b1);
        @(posedge clk);
        #1;
        chk("bp out_valid_u drop", {31'b0, ifu.out_valid}, 32'd0);
        chk("bp in_ready_s back",  {31'b0, ifs.in_ready},  32'd1);

        // Asynchronous reset in the middle of CALC aborts with no output.
        start_op(16'h1234, 8'h05);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst out_valid_u", {31'b0, ifu.out_valid}, 32'd0);
        chk("arst out_valid_s", {31'b0, ifs.out_valid}, 32'd0);
        chk("arst quot_u",      {16'b0, ifu.quotient},  32'd0);
        chk("arst rem_s",       {24'b0, ifs.remainder}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready_u", {31'b0, ifu.in_ready}, 32'd1);
        chk("post-rst in_ready_s", {31'b0, ifs.in_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (ifu.out_valid || ifs.out_valid) seen = 1'b1;
        end
        chk("aborted op silent", {31'b0, seen}, 32'd0);
        run_vec(vt[6]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
